// File: rtl/wb_writeback_stage.sv
// wb_writeback_stage: MEM/WB register and GPR write-port driver with a 1-entry mul/div buffer
module wb_writeback_stage #(
  parameter int MD_MAX_WAIT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        flush,
  input  logic        mem_regwrite,
  input  logic [1:0]  mem_wb_sel,
  input  logic [4:0]  mem_rd,
  input  logic [31:0] mem_alu,
  input  logic [31:0] mem_rdata,
  input  logic [2:0]  mem_ldtype,
  input  logic [1:0]  mem_addr_lo,
  input  logic [31:0] mem_pc,
  input  logic        md_valid,
  input  logic [4:0]  md_rd,
  input  logic [31:0] md_data,
  output logic        md_ready,
  output logic        stall_req,
  output logic        misalign,
  output logic        WE,
  output logic [4:0]  WeSel,
  output logic [31:0] WData
);
  localparam int WW = $clog2(MD_MAX_WAIT + 1);
  typedef enum logic [1:0] {SEL_ALU = 2'b00, SEL_LOAD = 2'b01, SEL_LINK = 2'b10, SEL_NONE = 2'b11} wb_sel_e;
  typedef enum logic [2:0] {LD_W = 3'b000, LD_B = 3'b001, LD_BU = 3'b010, LD_H = 3'b011, LD_HU = 3'b100} ld_e;
  logic          fresh_q, regwrite_q;
  wb_sel_e       sel_q;
  logic [4:0]    rd_q;
  logic [31:0]   alu_q, rdata_q, pc_q;
  logic [2:0]    ldtype_q;
  logic [1:0]    lo_q;
  logic          buf_full_q, buf_full_d;
  logic [4:0]    buf_rd_q, buf_rd_d;
  logic [31:0]   buf_data_q, buf_data_d;
  logic [WW-1:0] wait_q, wait_d;
  logic          we_q, we_d, mis_q, mis_d;
  logic [4:0]    wesel_q, wesel_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [7:0]    ld_byte;
  logic [15:0]   ld_half;
  logic [31:0]   ld_data, wr_data;
  logic          is_byte, is_half, misaligned, pipe_act, pipe_we, discard, drain, accept;
  // fresh_q marks a newly captured instruction so a held one never writes twice
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      fresh_q    <= 1'b0;
      regwrite_q <= 1'b0;
      sel_q      <= SEL_ALU;
      rd_q       <= '0;
      alu_q      <= '0;
      rdata_q    <= '0;
      ldtype_q   <= '0;
      lo_q       <= '0;
      pc_q       <= '0;
    end else if (flush) begin
      fresh_q    <= 1'b0;
      regwrite_q <= 1'b0;
    end else if (!stall) begin
      fresh_q    <= 1'b1;
      regwrite_q <= mem_regwrite;
      sel_q      <= wb_sel_e'(mem_wb_sel);
      rd_q       <= mem_rd;
      alu_q      <= mem_alu;
      rdata_q    <= mem_rdata;
      ldtype_q   <= mem_ldtype;
      lo_q       <= mem_addr_lo;
      pc_q       <= mem_pc;
    end else begin
      fresh_q    <= 1'b0;
    end
  // big-endian lanes: byte 0 is the most significant byte of the word
  always_comb begin
    ld_byte    = lo_q == 2'd0 ? rdata_q[31:24] : lo_q == 2'd1 ? rdata_q[23:16] :
                 lo_q == 2'd2 ? rdata_q[15:8] : rdata_q[7:0];
    ld_half    = lo_q[1] ? rdata_q[15:0] : rdata_q[31:16];
    is_byte    = ldtype_q == LD_B || ldtype_q == LD_BU;
    is_half    = ldtype_q == LD_H || ldtype_q == LD_HU;
    misaligned = is_half ? lo_q[0] : !is_byte && lo_q != 2'd0;
    ld_data    = ldtype_q == LD_B  ? {{24{ld_byte[7]}}, ld_byte} :
                 ldtype_q == LD_BU ? {24'd0, ld_byte} :
                 ldtype_q == LD_H  ? {{16{ld_half[15]}}, ld_half} :
                 ldtype_q == LD_HU ? {16'd0, ld_half} : rdata_q;
    wr_data    = sel_q == SEL_LINK ? pc_q + 32'd8 : sel_q == SEL_LOAD ? ld_data : alu_q;
  end
  // pipeline writes win; the buffer drains only in slots the pipeline leaves empty
  always_comb begin
    pipe_act   = fresh_q && regwrite_q && sel_q != SEL_NONE;
    mis_d      = pipe_act && sel_q == SEL_LOAD && misaligned;
    pipe_we    = pipe_act && !mis_d && rd_q != 5'd0;
    discard    = pipe_we && buf_full_q && buf_rd_q == rd_q;
    drain      = !pipe_we && buf_full_q;
    accept     = md_valid && !buf_full_q;
    we_d       = pipe_we || (drain && buf_rd_q != 5'd0);
    wesel_d    = pipe_we ? rd_q : drain ? buf_rd_q : 5'd0;
    wdata_d    = pipe_we ? wr_data : drain ? buf_data_q : 32'd0;
    buf_full_d = buf_full_q ? !(drain || discard) : accept;
    buf_rd_d   = accept ? md_rd : buf_rd_q;
    buf_data_d = accept ? md_data : buf_data_q;
    wait_d     = !(buf_full_q && pipe_we && !discard) ? '0 :
                 wait_q == WW'(MD_MAX_WAIT) ? wait_q : wait_q + WW'(1);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      buf_full_q <= 1'b0;
      buf_rd_q   <= '0;
      buf_data_q <= '0;
      wait_q     <= '0;
      we_q       <= 1'b0;
      mis_q      <= 1'b0;
      wesel_q    <= '0;
      wdata_q    <= '0;
    end else begin
      buf_full_q <= buf_full_d;
      buf_rd_q   <= buf_rd_d;
      buf_data_q <= buf_data_d;
      wait_q     <= wait_d;
      we_q       <= we_d;
      mis_q      <= mis_d;
      wesel_q    <= wesel_d;
      wdata_q    <= wdata_d;
    end
  assign md_ready  = !buf_full_q;
  assign stall_req = wait_q >= WW'(MD_MAX_WAIT);
  assign misalign  = mis_q;
  assign WE        = we_q;
  assign WeSel     = wesel_q;
  assign WData     = wdata_q;
endmodule

// File: tb/tb_wb_writeback_stage.sv
// tb_wb_writeback_stage: scoreboard bench with a transaction-level reference model
module tb_wb_writeback_stage;
  localparam int MAXW = 4;
  logic clk = 1'b0, rst_n = 1'b0, stall = 1'b0, flush = 1'b0, mem_regwrite = 1'b0;
  logic [1:0] mem_wb_sel = '0, mem_addr_lo = '0;
  logic [4:0] mem_rd = '0, md_rd = '0;
  logic [31:0] mem_alu = '0, mem_rdata = '0, mem_pc = '0, md_data = '0;
  logic [2:0] mem_ldtype = '0;
  logic md_valid = 1'b0;
  logic md_ready, stall_req, misalign, WE;
  logic [4:0] WeSel;
  logic [31:0] WData;
  wb_writeback_stage #(.MD_MAX_WAIT(MAXW)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .mem_regwrite(mem_regwrite),
    .mem_wb_sel(mem_wb_sel), .mem_rd(mem_rd), .mem_alu(mem_alu), .mem_rdata(mem_rdata),
    .mem_ldtype(mem_ldtype), .mem_addr_lo(mem_addr_lo), .mem_pc(mem_pc), .md_valid(md_valid),
    .md_rd(md_rd), .md_data(md_data), .md_ready(md_ready), .stall_req(stall_req),
    .misalign(misalign), .WE(WE), .WeSel(WeSel), .WData(WData));
  always #5 clk = ~clk;
  typedef struct { int cyc; bit we; bit mis; logic [4:0] rd; logic [31:0] data; } exp_t;
  exp_t q[$];
  int errors = 0, checks = 0, cyc_n = 0;
  bit run = 1'b0, saw_sr = 1'b0;
  bit p_w = 1'b0, p_m = 1'b0, b_full = 1'b0;
  logic [4:0] p_rd = '0, b_rd = '0;
  logic [31:0] p_data = '0, b_data = '0;
  int b_age = 0;
  task automatic check(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc_n);
    end
  endtask
  function automatic logic [31:0] load_val(logic [31:0] w, logic [2:0] t, logic [1:0] a);
    logic [7:0] b;
    logic [15:0] h;
    b = 8'(w >> (8 * (3 - int'(a))));
    h = 16'(w >> (a[1] ? 0 : 16));
    case (t)
      3'd1: return {{24{b[7]}}, b};
      3'd2: return {24'd0, b};
      3'd3: return {{16{h[15]}}, h};
      3'd4: return {16'd0, h};
      default: return w;
    endcase
  endfunction
  function automatic bit misal(logic [2:0] t, logic [1:0] a);
    return (t == 3 || t == 4) ? a[0] : (t == 1 || t == 2) ? 1'b0 : a != 0;
  endfunction
  // one clock edge of the reference: present, then buffer accept, then capture
  task automatic model_update();
    exp_t e;
    bit was_full = b_full;
    cyc_n++;
    e.cyc = cyc_n; e.we = 0; e.mis = p_m; e.rd = '0; e.data = '0;
    if (p_w) begin
      e.we = 1; e.rd = p_rd; e.data = p_data;
      if (b_full && b_rd == p_rd) begin b_full = 0; b_age = 0; end
      else if (b_full) b_age++;
    end else if (b_full) begin
      if (b_rd != 0) begin e.we = 1; e.rd = b_rd; e.data = b_data; end
      b_full = 0; b_age = 0;
    end
    if (e.we || e.mis) q.push_back(e);
    if (!was_full && md_valid) begin b_full = 1; b_rd = md_rd; b_data = md_data; b_age = 0; end
    p_w = 0; p_m = 0;
    if (!flush && !stall && mem_regwrite && mem_wb_sel != 2'd3) begin
      if (mem_wb_sel == 2'd1 && misal(mem_ldtype, mem_addr_lo)) p_m = 1;
      else if (mem_rd != 0) begin
        p_w = 1; p_rd = mem_rd;
        p_data = mem_wb_sel == 2'd0 ? mem_alu : mem_wb_sel == 2'd2 ? mem_pc + 32'd8 :
                 load_val(mem_rdata, mem_ldtype, mem_addr_lo);
      end
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    model_update();
    #1;
  endtask
  task automatic pipe(bit rw, logic [1:0] sel, logic [4:0] rd, logic [31:0] alu, logic [31:0] rdata,
                      logic [2:0] lt, logic [1:0] lo, logic [31:0] pc);
    mem_regwrite = rw; mem_wb_sel = sel; mem_rd = rd; mem_alu = alu; mem_rdata = rdata;
    mem_ldtype = lt; mem_addr_lo = lo; mem_pc = pc;
  endtask
  task automatic idle();
    mem_regwrite = 0; md_valid = 0; stall = 0; flush = 0;
  endtask
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && run) begin
      check("md_ready", md_ready, !b_full);
      check("stall_req", stall_req, b_age >= MAXW);
      if (stall_req) saw_sr = 1;
      while (q.size() > 0 && q[0].cyc < cyc_n) begin
        e = q.pop_front();
        checks++; errors++;
        $display("FAIL missing_write: got nothing expected rd=%0d data=%h mis=%0d at cycle %0d",
                 e.rd, e.data, e.mis, e.cyc);
      end
      if (q.size() > 0 && q[0].cyc == cyc_n) begin
        e = q.pop_front();
        check("WE", WE, e.we);
        check("misalign", misalign, e.mis);
        if (e.we) begin
          check("WeSel", WeSel, e.rd);
          check("WData", WData, e.data);
        end
      end else if (WE || misalign) begin
        checks++; errors++;
        $display("FAIL unexpected_write: got WE=%0d WeSel=%0d WData=%h misalign=%0d expected none",
                 WE, WeSel, WData, misalign);
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
  logic [2:0] lts [5] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd0};
  logic [1:0] los [5] = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd2};
  initial begin
    #12;
    check("rst_WE", WE, 0); check("rst_WeSel", WeSel, 0); check("rst_WData", WData, 0);
    check("rst_md_ready", md_ready, 1); check("rst_stall_req", stall_req, 0);
    check("rst_misalign", misalign, 0);
    @(negedge clk); rst_n = 1; run = 1;
    pipe(1, 2'd0, 5'd5, 32'h12345678, 0, 0, 0, 0); cyc(); idle(); repeat (3) cyc();
    for (int i = 0; i < 5; i++) begin
      pipe(1, 2'd1, 5'(10 + i), 0, 32'h80FF7F01, lts[i], los[i], 0); cyc();
    end
    idle(); repeat (2) cyc();
    pipe(1, 2'd2, 5'd31, 0, 0, 0, 0, 32'h00400010); cyc();
    pipe(1, 2'd0, 5'd0, 32'h0000FFFF, 0, 0, 0, 0); cyc(); idle(); repeat (2) cyc();
    md_valid = 1; md_rd = 9; md_data = 32'hDEAD0000; cyc(); md_valid = 0; repeat (3) cyc();
    md_valid = 1; md_rd = 9; md_data = 32'h5A5A0009;
    for (int i = 0; i < 20 && !stall_req; i++) begin
      pipe(1, 2'd0, 5'(1 + i % 6), $urandom, 0, 0, 0, 0); cyc(); md_valid = 0;
    end
    check("starve_stall_req", stall_req, 1);
    stall = 1; repeat (3) cyc(); idle(); repeat (2) cyc();
    pipe(1, 2'd0, 5'd3, 32'h33333333, 0, 0, 0, 0); md_valid = 1; md_rd = 7; md_data = 32'h77770000;
    cyc(); md_valid = 0; cyc();
    pipe(1, 2'd0, 5'd7, 32'hAAAA7777, 0, 0, 0, 0); cyc(); idle(); repeat (3) cyc();
    pipe(1, 2'd0, 5'd3, 32'h0BAD0003, 0, 0, 0, 0); md_valid = 1; md_rd = 12; md_data = 32'h12121212;
    cyc(); md_valid = 0; repeat (2) cyc();
    #2 rst_n = 0; #1;
    check("async_rst_WE", WE, 0); check("async_rst_md_ready", md_ready, 1);
    check("async_rst_stall_req", stall_req, 0);
    p_w = 0; p_m = 0; b_full = 0; b_age = 0; q.delete(); idle();
    @(negedge clk); rst_n = 1;
    for (int i = 0; i < 400; i++) begin
      stall = $urandom_range(0, 7) == 0; flush = $urandom_range(0, 15) == 0;
      pipe($urandom_range(0, 3) != 0, 2'($urandom), 5'($urandom_range(0, 7)), $urandom, $urandom,
           3'($urandom_range(0, 4)), 2'($urandom), $urandom);
      md_valid = $urandom_range(0, 2) == 0; md_rd = 5'($urandom_range(0, 7)); md_data = $urandom;
      cyc();
    end
    idle(); repeat (6) cyc();
    check("queue_drained", q.size(), 0);
    check("saw_stall_req", saw_sr, 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
